rf_wb_scheduler: RTL and testbench

- Owns the single write port of the 32x32 GPR file: merges in-order pipeline writeback with out-of-order writeback from the multi-cycle mul/div unit (MDU).
- Keeps a per-register busy scoreboard for MDU destinations and drives the ID-stage stall for RAW/WAW hazards against pending MDU results.
- Sits between the MEM/WB stage, the MDU and the register file; its outputs drive RegWrite/WriteRegister/WriteData directly.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/rf_scoreboard.sv | 66 ++++++
 rtl/rf_wb_scheduler.sv | 111 +++++++++++
 tb/tb_rf_wb_scheduler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared register-file geometry and the write-port request type.
package cpu_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // One register-file write as seen on the write port.
  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wr_req_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard for the single outstanding MDU result and the ID-stage
// hazard stall derived from it.
module rf_scoreboard
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_issue,
  input  logic [REG_ADDR_W-1:0] i_issue_rd,
  input  logic                  i_xfer,
  input  logic [REG_ADDR_W-1:0] i_xfer_rd,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic [REG_ADDR_W-1:0] i_id_rd,
  input  logic                  i_id_uses_rt,
  input  logic                  i_id_writes,
  input  logic                  i_issue_req,
  output logic                  o_idle,
  output logic                  o_stall
);
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic                r_idle;
  logic                w_idle_nxt;
  logic                w_issue_acc;

  // An issue is only taken while nothing is outstanding.
  assign w_issue_acc = i_issue & r_idle;

  // Completion clears first, then a new issue sets, so a same-register
  // issue in the completion cycle leaves the bit set.
  always_comb begin
    w_busy_nxt = r_busy;
    w_idle_nxt = r_idle;
    if (i_xfer) begin
      w_busy_nxt[i_xfer_rd] = 1'b0;
      w_idle_nxt            = 1'b1;
    end
    if (w_issue_acc) begin
      w_idle_nxt = 1'b0;
      if (i_issue_rd != REG_ZERO) w_busy_nxt[i_issue_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Scoreboard state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      r_idle <= 1'b1;
    end else begin
      r_busy <= w_busy_nxt;
      r_idle <= w_idle_nxt;
    end
  end

  // Stall uses registered busy bits: a completing result releases next cycle.
  always_comb begin
    o_stall = r_busy[i_id_rs]
            | (i_id_uses_rt & r_busy[i_id_rt])
            | (i_id_writes  & r_busy[i_id_rd])
            | (i_issue_req  & ~r_idle);
  end

  assign o_idle = r_idle;
endmodule

// File: rtl/rf_wb_scheduler.sv
// Single register-file write port shared by in-order pipeline writeback and
// the out-of-order MDU result, with starvation relief for the MDU.
module rf_wb_scheduler
  import cpu_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_we,
  input  logic [REG_ADDR_W-1:0] pipe_waddr,
  input  logic [DATA_W-1:0]     pipe_wdata,
  output logic                  pipe_hold,
  input  logic                  mdu_issue,
  input  logic [REG_ADDR_W-1:0] mdu_issue_rd,
  output logic                  mdu_idle,
  input  logic                  mdu_valid,
  input  logic [REG_ADDR_W-1:0] mdu_rd,
  input  logic [DATA_W-1:0]     mdu_data,
  output logic                  mdu_ready,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_uses_rt,
  input  logic                  id_writes,
  output logic                  id_stall,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0]     WriteData
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic             r_pipe_hold;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_grant_pipe;
  logic             w_mdu_ready;
  logic             w_xfer;
  logic             w_blocked;
  wr_req_t          r_wr;
  wr_req_t          w_wr_nxt;

  // Pipeline wins every conflict except during the one-cycle hold.
  assign w_grant_pipe = pipe_we & ~r_pipe_hold;
  assign w_mdu_ready  = mdu_valid & (~pipe_we | r_pipe_hold);
  assign w_xfer       = mdu_valid & w_mdu_ready;
  assign w_blocked    = mdu_valid & ~w_mdu_ready;

  // Count consecutive blocked cycles, saturating at the limit.
  always_comb begin
    w_cnt_nxt = '0;
    if (w_blocked) w_cnt_nxt = (r_cnt == LIMIT) ? r_cnt : r_cnt + 1'b1;
  end

  // Hold fires for one cycle once the count reaches the limit; in the hold
  // cycle the MDU is always ready, so the count clears there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_pipe_hold <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_pipe_hold <= (w_cnt_nxt == LIMIT) & ~r_pipe_hold;
    end
  end

  // Select the winning write; register 0 writes complete but never assert we.
  always_comb begin
    w_wr_nxt    = r_wr;
    w_wr_nxt.we = 1'b0;
    if (w_grant_pipe) begin
      w_wr_nxt.we   = (pipe_waddr != REG_ZERO);
      w_wr_nxt.addr = pipe_waddr;
      w_wr_nxt.data = pipe_wdata;
    end else if (w_xfer) begin
      w_wr_nxt.we   = (mdu_rd != REG_ZERO);
      w_wr_nxt.addr = mdu_rd;
      w_wr_nxt.data = mdu_data;
    end
  end

  // Registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_wr <= '0;
    else     r_wr <= w_wr_nxt;
  end

  rf_scoreboard u_sb (
    .clk          (clk),
    .rst          (rst),
    .i_issue      (mdu_issue),
    .i_issue_rd   (mdu_issue_rd),
    .i_xfer       (w_xfer),
    .i_xfer_rd    (mdu_rd),
    .i_id_rs      (id_rs),
    .i_id_rt      (id_rt),
    .i_id_rd      (id_rd),
    .i_id_uses_rt (id_uses_rt),
    .i_id_writes  (id_writes),
    .i_issue_req  (mdu_issue),
    .o_idle       (mdu_idle),
    .o_stall      (id_stall)
  );

  assign pipe_hold     = r_pipe_hold;
  assign mdu_ready     = w_mdu_ready;
  assign RegWrite      = r_wr.we;
  assign WriteRegister = r_wr.addr;
  assign WriteData     = r_wr.data;
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler: write port, arbitration, starvation
// hold, scoreboard hazards and asynchronous reset.
module tb_rf_wb_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        pipe_hold;
  logic        mdu_issue;
  logic [4:0]  mdu_issue_rd;
  logic        mdu_idle;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rt, id_writes;
  logic        id_stall;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;

  int checks   = 0;
  int failures = 0;

  rf_wb_scheduler #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .pipe_hold(pipe_hold),
    .mdu_issue(mdu_issue), .mdu_issue_rd(mdu_issue_rd), .mdu_idle(mdu_idle),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .id_writes(id_writes), .id_stall(id_stall),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    pipe_we = 0; pipe_waddr = 0; pipe_wdata = 0;
    mdu_issue = 0; mdu_issue_rd = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_uses_rt = 0; id_writes = 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    #2;
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_waddr", WriteRegister, 0);
    chk("rst_wdata", WriteData, 0);
    chk("rst_idle", mdu_idle, 1);
    chk("rst_hold", pipe_hold, 0);
    chk("rst_stall", id_stall, 0);
    chk("rst_ready", mdu_ready, 0);
    #10 rst = 0;
    tick();

    // Pipeline-only writes, including register 0.
    pipe_we = 1; pipe_waddr = 7; pipe_wdata = 32'hDEADBEEF;
    #1;
    chk("pipe_ready0", mdu_ready, 0);
    tick();
    chk("pipe_we", RegWrite, 1);
    chk("pipe_addr", WriteRegister, 7);
    chk("pipe_data", WriteData, 32'hDEADBEEF);
    pipe_waddr = 0; pipe_wdata = 32'h1234;
    tick();
    chk("pipe_r0_we", RegWrite, 0);
    pipe_we = 0;

    // Issue to r9, then conflict pipe r3 vs MDU r9.
    mdu_issue = 1; mdu_issue_rd = 9;
    #1;
    chk("issue9_stall", id_stall, 0);
    tick();
    mdu_issue = 0;
    chk("issue9_idle", mdu_idle, 0);
    pipe_we = 1; pipe_waddr = 3; pipe_wdata = 32'h33;
    mdu_valid = 1; mdu_rd = 9; mdu_data = 32'h99; id_rs = 9;
    #1;
    chk("conf_ready", mdu_ready, 0);
    chk("conf_stall", id_stall, 1);
    tick();
    chk("conf_pipe_addr", WriteRegister, 3);
    chk("conf_pipe_we", RegWrite, 1);
    pipe_we = 0;
    #1;
    chk("conf_ready2", mdu_ready, 1);
    chk("conf_stall_hold", id_stall, 1);
    tick();
    mdu_valid = 0;
    chk("conf_mdu_we", RegWrite, 1);
    chk("conf_mdu_addr", WriteRegister, 9);
    chk("conf_mdu_data", WriteData, 32'h99);
    chk("conf_idle", mdu_idle, 1);
    #1;
    chk("conf_stall_rel", id_stall, 0);

    // Hazards against a pending r12.
    mdu_issue = 1; mdu_issue_rd = 12; id_rs = 0;
    tick();
    mdu_issue = 0;
    id_rs = 12;
    #1;
    chk("haz_rs", id_stall, 1);
    id_rs = 0; id_rt = 12; id_uses_rt = 0;
    #1;
    chk("haz_rt_unused", id_stall, 0);
    id_uses_rt = 1;
    #1;
    chk("haz_rt_used", id_stall, 1);
    id_uses_rt = 0; id_rt = 0; id_rd = 12; id_writes = 1;
    #1;
    chk("haz_waw", id_stall, 1);
    id_writes = 0; id_rd = 0; mdu_issue = 1; mdu_issue_rd = 5;
    #1;
    chk("haz_issue_busy", id_stall, 1);
    mdu_issue = 0;

    // Starvation: MDU r12 blocked by four pipeline writes, then hold.
    pipe_we = 1; mdu_valid = 1; mdu_rd = 12; mdu_data = 32'hC0FFEE; id_rs = 12;
    for (int i = 0; i < 4; i++) begin
      pipe_waddr = 5'(20 + i); pipe_wdata = 100 + i;
      #1;
      chk("starve_hold0", pipe_hold, 0);
      chk("starve_ready0", mdu_ready, 0);
      chk("starve_stall", id_stall, 1);
      tick();
      chk("starve_pipe_addr", WriteRegister, 20 + i);
      chk("starve_pipe_we", RegWrite, 1);
    end
    pipe_waddr = 24; pipe_wdata = 124;
    #1;
    chk("starve_hold1", pipe_hold, 1);
    chk("starve_ready1", mdu_ready, 1);
    tick();
    mdu_valid = 0;
    chk("starve_mdu_addr", WriteRegister, 12);
    chk("starve_mdu_data", WriteData, 32'hC0FFEE);
    chk("starve_mdu_we", RegWrite, 1);
    chk("starve_hold_end", pipe_hold, 0);
    chk("starve_idle", mdu_idle, 1);
    #1;
    chk("starve_stall_rel", id_stall, 0);
    tick();
    chk("post_hold_pipe", WriteRegister, 24);
    id_rs = 5;
    #1;
    chk("rejected_issue5", id_stall, 0);
    pipe_we = 0; id_rs = 0;

    // Same-cycle transfer to r4 and issue to r4 from idle.
    mdu_valid = 1; mdu_rd = 4; mdu_data = 32'h44;
    mdu_issue = 1; mdu_issue_rd = 4;
    #1;
    chk("same_ready", mdu_ready, 1);
    chk("same_stall0", id_stall, 0);
    tick();
    mdu_issue = 0; mdu_valid = 0; id_rs = 4;
    #1;
    chk("same_we", RegWrite, 1);
    chk("same_addr", WriteRegister, 4);
    chk("same_idle", mdu_idle, 0);
    chk("same_busy4", id_stall, 1);

    // Retire r4, issue r5, starve it three cycles, then reset mid-stream.
    mdu_valid = 1; mdu_rd = 4;
    tick();
    mdu_valid = 0; mdu_issue = 1; mdu_issue_rd = 5; id_rs = 0;
    tick();
    mdu_issue = 0; id_rs = 5;
    #1;
    chk("pre_rst_busy5", id_stall, 1);
    pipe_we = 1; pipe_waddr = 6; pipe_wdata = 32'h66;
    mdu_valid = 1; mdu_rd = 5; mdu_data = 32'h55;
    repeat (3) tick();
    chk("pre_rst_we", RegWrite, 1);
    #1 rst = 1;
    #1;
    chk("mid_rst_we", RegWrite, 0);
    chk("mid_rst_addr", WriteRegister, 0);
    chk("mid_rst_data", WriteData, 0);
    chk("mid_rst_idle", mdu_idle, 1);
    chk("mid_rst_hold", pipe_hold, 0);
    chk("mid_rst_stall", id_stall, 0);
    #1 rst = 0;
    tick();
    chk("post_rst_hold", pipe_hold, 0);
    chk("post_rst_ready", mdu_ready, 0);
    clear_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
